// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: combinational controls from FSM state + hazard inputs.
// Optional perf counters (stall_cycles, flush_events) are built when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       id_redirect,
  input  logic       ex_load,
  input  logic       ex_wen,
  input  logic [4:0] ex_rd,
  input  logic       ex_md_valid,
  input  logic       ex_md_is_div,
  input  logic       mem_req,
  input  logic       mem_ack,
  input  logic       trap_i,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       flush_if_id,
  output logic       stall_id_ex,
  output logic       flush_id_ex,
  output logic       stall_ex_mem,
  output logic       flush_ex_mem,
  output logic       wb_bubble,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [63:0] stall_cycles,
  output logic [63:0] flush_events
`endif
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // The entry cycle counts as the first EX cycle and cnt==0 is the result cycle, hence N-2.
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);
  localparam logic             MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic             DIV_MULTI = (DIV_CYCLES > 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic             mem_stall;
  logic             n_multi;
  logic [CNT_W-1:0] n_load;
  logic             md_enter;
  logic             md_hold;
  logic             md_stall;
  logic             md_fin;
  logic             rs_match;
  logic             load_use;

  assign mem_stall = mem_req && !mem_ack;
  assign n_multi   = ex_md_is_div ? DIV_MULTI : MUL_MULTI;
  assign n_load    = ex_md_is_div ? DIV_LD : MUL_LD;
  assign md_enter  = (state == RUN) && ex_md_valid && n_multi;
  assign md_hold   = (state == MD_BUSY) && (cnt != '0);
  assign md_stall  = md_enter || md_hold;
  assign md_fin    = ((state == RUN) && ex_md_valid && !n_multi) ||
                     ((state == MD_BUSY) && (cnt == '0));
  assign rs_match  = (id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd));
  assign load_use  = (state == RUN) && ex_load && ex_wen && (ex_rd != 5'd0) && rs_match;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (trap_i) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else if (mem_stall) begin
      state_nxt = state;
      cnt_nxt   = cnt;
    end else if (state == RUN) begin
      if (md_enter) begin
        state_nxt = MD_BUSY;
        cnt_nxt   = n_load;
      end
    end else begin
      if (cnt != '0) begin
        cnt_nxt = cnt - CNT_W'(1);
      end else begin
        state_nxt = RUN;
      end
    end
  end

  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    flush_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    flush_ex_mem = 1'b0;
    wb_bubble    = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    if (!reset) begin
      md_busy = (state == MD_BUSY);
      if (trap_i) begin
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
      end else if (mem_stall) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        wb_bubble    = 1'b1;
      end else if (md_stall) begin
        // MEM gets a bubble while the op sits in EX.
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
      end else begin
        md_done = md_fin;
        if (load_use) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (id_redirect) begin
          flush_if_id = 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic any_flush;
  assign any_flush = flush_if_id || flush_id_ex || flush_ex_mem;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_pc && !(&stall_cycles)) begin
        stall_cycles <= stall_cycles + 64'd1;
      end
      if (any_flush && !(&flush_events)) begin
        flush_events <= flush_events + 64'd1;
      end
    end
  end
`endif

endmodule
